// File: rtl/vga_bounce_box.sv
// Pixel stage for the 640x480@60 VGA path: draws a bouncing square on a dark-blue field.
// The box moves once per frame, reflects off the active-area edges and recolours on each bounce.
module vga_bounce_box #(
    parameter int unsigned H_ACTIVE_START = 144,
    parameter int unsigned H_ACTIVE_END   = 783,
    parameter int unsigned V_ACTIVE_START = 35,
    parameter int unsigned V_ACTIVE_END   = 514,
    parameter int unsigned BOX_SIZE       = 32,
    parameter int unsigned STEP           = 2
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic [15:0] H_count_value,
    input  logic [15:0] V_count_value,
    input  logic        enable,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        frame_tick
);

    localparam int unsigned CW        = 11;
    localparam int unsigned XW        = 10;
    localparam int unsigned YW        = 9;
    localparam int unsigned H_VISIBLE = H_ACTIVE_END - H_ACTIVE_START + 1;
    localparam int unsigned V_VISIBLE = V_ACTIVE_END - V_ACTIVE_START + 1;
    localparam int unsigned X_LIMIT   = H_VISIBLE - BOX_SIZE;
    localparam int unsigned Y_LIMIT   = V_VISIBLE - BOX_SIZE;
    localparam int unsigned X_RESET   = 304;
    localparam int unsigned Y_RESET   = 224;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            update_c;

    logic [XW-1:0]   box_x;
    logic [YW-1:0]   box_y;
    logic            dir_x;
    logic            dir_y;
    logic [2:0]      col_idx;

    logic [XW-1:0]   box_x_nxt;
    logic [YW-1:0]   box_y_nxt;
    logic            dir_x_nxt;
    logic            dir_y_nxt;
    logic [2:0]      col_idx_nxt;
    logic            hit_x_c;
    logic            hit_y_c;

    logic            frame_event_c;
    logic            active_c;
    logic [CW-1:0]   x_c;
    logic [CW-1:0]   y_c;
    logic            in_box_c;
    logic [11:0]     box_rgb_c;
    logic [11:0]     pix_c;

    assign frame_event_c = (H_count_value == 16'(0)) &&
                           (V_count_value == 16'(V_ACTIVE_END + 1));

    // Anything outside the visible window, including out-of-range counts, is blanking
    assign active_c = (H_count_value >= 16'(H_ACTIVE_START)) &&
                      (H_count_value <= 16'(H_ACTIVE_END))   &&
                      (V_count_value >= 16'(V_ACTIVE_START)) &&
                      (V_count_value <= 16'(V_ACTIVE_END));

    assign x_c = CW'(H_count_value - 16'(H_ACTIVE_START));
    assign y_c = CW'(V_count_value - 16'(V_ACTIVE_START));

    assign in_box_c = active_c &&
                      (x_c >= CW'(box_x)) && (x_c < CW'(box_x) + CW'(BOX_SIZE)) &&
                      (y_c >= CW'(box_y)) && (y_c < CW'(box_y) + CW'(BOX_SIZE));

    assign box_rgb_c = (col_idx == 3'd0) ? 12'hFFF
                     : {{4{col_idx[0]}}, {4{col_idx[1]}}, {4{col_idx[2]}}};

    always_comb begin
        pix_c = 12'h000;
        if (state != SYNC && active_c) begin
            pix_c = in_box_c ? box_rgb_c : 12'h002;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode changes and position updates happen only at frame events
    always_comb begin
        state_nxt = state;
        update_c  = 1'b0;
        case (state)
            SYNC: begin
                if (frame_event_c) begin
                    state_nxt = enable ? RUN : HOLD;
                end
            end
            RUN: begin
                if (frame_event_c) begin
                    if (enable) begin
                        update_c = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (frame_event_c && enable) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_comb begin
        box_x_nxt   = box_x;
        box_y_nxt   = box_y;
        dir_x_nxt   = dir_x;
        dir_y_nxt   = dir_y;
        col_idx_nxt = col_idx;
        hit_x_c     = 1'b0;
        hit_y_c     = 1'b0;
        if (update_c) begin
            if (dir_x) begin
                if (CW'(box_x) + CW'(STEP) > CW'(X_LIMIT)) begin
                    box_x_nxt = XW'(X_LIMIT);
                    dir_x_nxt = 1'b0;
                    hit_x_c   = 1'b1;
                end else begin
                    box_x_nxt = box_x + XW'(STEP);
                end
            end else begin
                if (CW'(box_x) < CW'(STEP)) begin
                    box_x_nxt = '0;
                    dir_x_nxt = 1'b1;
                    hit_x_c   = 1'b1;
                end else begin
                    box_x_nxt = box_x - XW'(STEP);
                end
            end

            if (dir_y) begin
                if (CW'(box_y) + CW'(STEP) > CW'(Y_LIMIT)) begin
                    box_y_nxt = YW'(Y_LIMIT);
                    dir_y_nxt = 1'b0;
                    hit_y_c   = 1'b1;
                end else begin
                    box_y_nxt = box_y + YW'(STEP);
                end
            end else begin
                if (CW'(box_y) < CW'(STEP)) begin
                    box_y_nxt = '0;
                    dir_y_nxt = 1'b1;
                    hit_y_c   = 1'b1;
                end else begin
                    box_y_nxt = box_y - YW'(STEP);
                end
            end

            // A corner hit still advances the colour by one
            if (hit_x_c || hit_y_c) begin
                col_idx_nxt = col_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            box_x      <= XW'(X_RESET);
            box_y      <= YW'(Y_RESET);
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            col_idx    <= 3'd0;
            Red        <= 4'h0;
            Green      <= 4'h0;
            Blue       <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            box_x      <= box_x_nxt;
            box_y      <= box_y_nxt;
            dir_x      <= dir_x_nxt;
            dir_y      <= dir_y_nxt;
            col_idx    <= col_idx_nxt;
            Red        <= pix_c[11:8];
            Green      <= pix_c[7:4];
            Blue       <= pix_c[3:0];
            frame_tick <= frame_event_c;
        end
    end

endmodule
